// File: rtl/fetch_queue.sv
// fetch_queue: PC register plus DEPTH-entry fetch queue drained by decode via valid/ready.
// Latency: 1 cycle fetch-to-out_valid; 0 on an empty queue when FETCH_BYPASS_EN is defined.
// Backpressure: fetch stalls when full unless decode pops in the same cycle; redirect flushes.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [ADDR_W-1:0]            address_imem,
  input  logic [DATA_W-1:0]            q_imem,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic pop;
  logic fetch;
  logic wr_en;
  logic rd_adv;
  logic bypass;

  assign address_imem = pc;
  assign count        = cnt;

  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass = (cnt == '0) & ~redirect_valid;
`endif
    out_valid = (cnt != '0) | bypass;
    out_instr = bypass ? q_imem : instr_mem[rd_ptr];
    out_pc    = bypass ? pc     : pc_mem[rd_ptr];
    pop       = out_valid & out_ready;
    fetch     = ~redirect_valid & ((cnt < CNT_W'(DEPTH)) | pop);
    // A bypassed word consumed directly by decode never touches storage.
    wr_en     = fetch & ~(bypass & out_ready);
    rd_adv    = pop & ~bypass;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (fetch)  pc     <= pc + ADDR_W'(1);
      if (wr_en)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_adv})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (wr_en) begin
      instr_mem[wr_ptr] <= q_imem;
      pc_mem[wr_ptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address_imem;
  logic [DW-1:0] q_imem;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] mpc;
  int            checks = 0;
  int            errors = 0;

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return 32'hA000_0000 + {24'h0, a};
  endfunction

  assign q_imem = word_at(address_imem);

  fetch_queue #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .RESET_PC(8'h00)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address_imem  (address_imem),
    .q_imem        (q_imem),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .count         (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check against the model, then advance it.
  task automatic step(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    bit   byp;
    bit   ev;
    bit   pop;
    bit   fetch;
    ent_t head;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    byp  = BYPASS && (mq.size() == 0) && !rv;
    ev   = (mq.size() > 0) || byp;
    head = byp ? {mpc, word_at(mpc)} : ((mq.size() > 0) ? mq[0] : '0);
    chk("address_imem", address_imem, mpc);
    chk("count", count, mq.size());
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_pc", out_pc, head.pc);
      chk("out_instr", out_instr, head.instr);
    end
    @(posedge clock);
    pop = ev && rdy;
    if (rv) begin
      mq.delete();
      mpc = rpc;
    end else if (byp) begin
      if (!rdy) mq.push_back({mpc, word_at(mpc)});
      mpc = mpc + 8'd1;
    end else begin
      fetch = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        mq.push_back({mpc, word_at(mpc)});
        mpc = mpc + 8'd1;
      end
    end
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_addr"}, address_imem, 8'h00);
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    mpc            = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;

    // Reset and drain: streaming one instruction per cycle.
    repeat (8) step(1'b0, 8'h00, 1'b1);

    // Backpressure to full from PC 0.
    step(1'b1, 8'h00, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b0);
    chk("full_count", count, 4);
    chk("full_addr", address_imem, 8'h04);
    chk("full_out_pc", out_pc, 8'h00);
    step(1'b0, 8'h00, 1'b1);
    chk("full_pop_count", count, 4);
    chk("full_pop_addr", address_imem, 8'h05);
    chk("full_pop_out_pc", out_pc, 8'h01);

    // Redirect mid-stream with three entries queued.
    step(1'b1, 8'h10, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    chk("mid_count3", count, 3);
    step(1'b1, 8'h40, 1'b1);
    chk("redir_count", count, 0);
    chk("redir_addr", address_imem, 8'h40);
    chk("redir_valid", out_valid, BYPASS);
    step(1'b0, 8'h00, 1'b1);
    chk("redir_target_pc", out_pc, BYPASS ? 8'h41 : 8'h40);

    // Back-to-back redirects: the last target wins.
    step(1'b1, 8'h20, 1'b1);
    step(1'b1, 8'h30, 1'b1);
    chk("b2b_count", count, 0);
    chk("b2b_addr", address_imem, 8'h30);

    // Redirect with a simultaneous pop while full.
    step(1'b1, 8'h60, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    chk("rpf_full", count, 4);
    step(1'b1, 8'h80, 1'b1);
    chk("rpf_count", count, 0);
    chk("rpf_addr", address_imem, 8'h80);

    // PC wrap through 0xFF.
    step(1'b1, 8'hFE, 1'b1);
    repeat (6) step(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) == 0), AW'($urandom), $urandom_range(1) == 1);
    end

    // Asynchronous reset between edges with two entries queued.
    step(1'b1, 8'h90, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    chk("pre_areset_count", count, 2);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("areset");
    mq.delete();
    mpc = 8'h00;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) step(1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the bare program-counter register at the head of the 5-stage pipeline. It holds the PC, drives the instruction-memory address, and captures fetched words with their PCs into a DEPTH-entry circular queue. Decode drains the queue through a valid/ready handshake. A redirect port from execute loads a new PC and flushes the queue on a taken branch or jump.

## Interface
- ADDR_W, 32, width of PC and imem address
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, PC value loaded on reset
- clock  in  1  master clock, rising-edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- address_imem  out  ADDR_W  current PC, driven straight from the PC register
- q_imem  in  DATA_W  instruction at address_imem, valid in the same cycle
- redirect_valid  in  1  flush queue and load redirect_pc
- redirect_pc  in  ADDR_W  branch/jump target
- out_valid  out  1  head entry available to decode
- out_instr  out  DATA_W  head instruction
- out_pc  out  ADDR_W  PC of the head instruction
- out_ready  in  1  decode accepts head this cycle
- count  out  clog2(DEPTH+1)  occupied entries

## Operation
- pop = out_valid & out_ready.
- fetch = !redirect_valid & ((count < DEPTH) | pop).
- On fetch, write {pc, q_imem} at wr_ptr and set pc to pc+1. The increment is modulo 2^ADDR_W, so it wraps from all-ones to 0.
- On pop, advance rd_ptr. Both pointers wrap modulo DEPTH.
- count update:
  - count+1 on fetch without pop.
  - count−1 on pop without fetch.
  - unchanged on both, or on neither.
- Full with simultaneous pop: fetch proceeds, count stays DEPTH, and the freed slot is reused.
- Empty: out_valid=0, and out_instr/out_pc show the stale entry at rd_ptr.
- Redirect has priority over everything:
  - pc ← redirect_pc; rd_ptr, wr_ptr and count ← 0.
  - No write and no pc increment in that cycle.
  - A pop in the redirect cycle completes, but its data is discarded upstream because it is on the wrong path.
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, pointers=0, count=0, out_valid=0.
  - Queue storage is cleared to 0, so out_instr=0 and out_pc=0.
- No internal FSM beyond the pointers and count; states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH).

## Timing
- address_imem changes only on a rising clock edge or on asynchronous reset.
- Without bypass:
  - Fetch-to-out_valid latency is 1 cycle.
  - First instruction after reset release appears 1 cycle after the first edge.
- Sustained throughput is 1 instruction/cycle whenever out_ready stays high.
- Redirect in cycle N:
  - Cycle N+1: address_imem=redirect_pc and count=0.
  - Target instruction reaches out_valid in N+2, or in N+1 with bypass.
- Back-to-back redirects: the last one wins, and the queue stays empty throughout.
- Reset release is synchronised externally; the block has no synchroniser.

## Configuration
- FETCH_BYPASS_EN defined: when count=0 and !redirect_valid, the fetched word goes straight to the output.
  - Outputs: out_valid=1, out_instr=q_imem, out_pc=pc.
  - If out_ready=1: pc advances and nothing is written.
  - If out_ready=0: the word is written and count becomes 1.
  - Empty-queue latency is 0 cycles.
- FETCH_BYPASS_EN undefined: the output always comes from queue storage, and empty-queue latency is 1 cycle.

## Test plan
- Reset and drain:
  - Stimulus: RESET_PC=0; hold reset=0 for 3 cycles, release, out_ready=1; q_imem returns 0xA000_0000+address.
  - Response: address_imem steps 0,1,2,… and out_pc/out_instr stream 0/0xA0000000, 1/0xA0000001, … one per cycle.
  - Response: first out_valid arrives 1 cycle after release (0 with bypass).
- Backpressure to full:
  - Stimulus: DEPTH=4, out_ready=0.
  - Response: count reaches 4, address_imem freezes at 4, and out_pc holds 0.
  - Stimulus: raise out_ready for 1 cycle.
  - Response: entry 0 popped, PC 4 fetched, count stays 4.
- Redirect mid-stream:
  - Stimulus: with count=3, pulse redirect_valid and redirect_pc=0x40.
  - Response: next cycle count=0, out_valid=0 (no bypass) and address_imem=0x40.
  - Response: the following cycle out_pc=0x40.
- Redirect with simultaneous pop while full:
  - Response: the pop completes, no write occurs, count=0, and pc=redirect_pc.
- PC wrap:
  - Stimulus: ADDR_W=8, redirect_pc=0xFE, out_ready=1.
  - Response: out_pc sequence is 0xFE, 0xFF, 0x00, 0x01.
- Asynchronous reset mid-operation:
  - Stimulus: with count=2, assert reset between clock edges.
  - Response: out_valid, count, out_instr and out_pc go to 0 immediately, and address_imem=RESET_PC before the next edge.
